// File: rtl/wb_mux_n_if.sv
// Wishbone classic bus bundle for wb_mux_n: one master side, NUM_SLAVES packed slave slices
// and the per-slave address map. The slave modport is the multiplexer's view.
interface wb_mux_n_if #(
  parameter int NUM_SLAVES   = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0]              wbm_adr_i;
  logic [DATA_WIDTH-1:0]              wbm_dat_i;
  logic [DATA_WIDTH-1:0]              wbm_dat_o;
  logic                               wbm_we_i;
  logic [SELECT_WIDTH-1:0]            wbm_sel_i;
  logic                               wbm_stb_i;
  logic                               wbm_cyc_i;
  logic                               wbm_ack_o;
  logic                               wbm_err_o;
  logic                               wbm_rty_o;

  logic [NUM_SLAVES*ADDR_WIDTH-1:0]   wbs_adr_o;
  logic [NUM_SLAVES*DATA_WIDTH-1:0]   wbs_dat_o;
  logic [NUM_SLAVES*DATA_WIDTH-1:0]   wbs_dat_i;
  logic [NUM_SLAVES-1:0]              wbs_we_o;
  logic [NUM_SLAVES*SELECT_WIDTH-1:0] wbs_sel_o;
  logic [NUM_SLAVES-1:0]              wbs_stb_o;
  logic [NUM_SLAVES-1:0]              wbs_cyc_o;
  logic [NUM_SLAVES-1:0]              wbs_ack_i;
  logic [NUM_SLAVES-1:0]              wbs_err_i;
  logic [NUM_SLAVES-1:0]              wbs_rty_i;

  logic [NUM_SLAVES*ADDR_WIDTH-1:0]   wbs_addr;
  logic [NUM_SLAVES*ADDR_WIDTH-1:0]   wbs_addr_msk;

  modport slave (
    input  wbm_adr_i, wbm_dat_i, wbm_we_i, wbm_sel_i, wbm_stb_i, wbm_cyc_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    output wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o, wbs_stb_o, wbs_cyc_o,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
    input  wbs_addr, wbs_addr_msk
  );

  modport master (
    output wbm_adr_i, wbm_dat_i, wbm_we_i, wbm_sel_i, wbm_stb_i, wbm_cyc_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    input  wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o, wbs_stb_o, wbs_cyc_o,
    output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
    output wbs_addr, wbs_addr_msk
  );
endinterface

// File: rtl/wb_mux_n.sv
// N-port Wishbone classic multiplexer with registered decode, per-transaction slave lock,
// selected-slave response qualification and an ACTIVE-state watchdog that terminates with err.
module wb_mux_n #(
  parameter int NUM_SLAVES     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic       clk,
  input logic       rst,
  wb_mux_n_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_ERR    = 2'd2;

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [1:0]            state, state_nxt;
  logic [IDX_W-1:0]      sel_idx, sel_idx_nxt;
  logic [WD_W-1:0]       wd_cnt, wd_cnt_nxt;

  logic                  req;
  logic                  hit;
  logic [IDX_W-1:0]      hit_idx;
  logic                  sel_ack, sel_err, sel_rty, sel_resp;
  logic                  timeout;
  logic [DATA_WIDTH-1:0] sel_dat;

  assign req = bus.wbm_cyc_i & bus.wbm_stb_i;

  // Descending scan so the lowest matching index is the one left standing.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (((bus.wbm_adr_i ^ bus.wbs_addr[i*ADDR_WIDTH +: ADDR_WIDTH]) &
           bus.wbs_addr_msk[i*ADDR_WIDTH +: ADDR_WIDTH]) == '0) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign sel_ack  = bus.wbs_ack_i[sel_idx];
  assign sel_err  = bus.wbs_err_i[sel_idx];
  assign sel_rty  = bus.wbs_rty_i[sel_idx];
  assign sel_resp = sel_ack | sel_err | sel_rty;
  assign sel_dat  = bus.wbs_dat_i[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];

  // A response in the limit cycle wins over the timeout.
  assign timeout = WD_EN && (state == ST_ACTIVE) && bus.wbm_cyc_i && !sel_resp &&
                   (wd_cnt == WD_LIMIT);

  always_comb begin
    state_nxt   = state;
    sel_idx_nxt = sel_idx;
    wd_cnt_nxt  = wd_cnt;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (hit) begin
            state_nxt   = ST_ACTIVE;
            sel_idx_nxt = hit_idx;
            wd_cnt_nxt  = '0;
          end else begin
            state_nxt = ST_ERR;
          end
        end
      end
      ST_ACTIVE: begin
        if (!bus.wbm_cyc_i || sel_resp) begin
          state_nxt = ST_IDLE;
        end else if (timeout) begin
          state_nxt = ST_ERR;
        end else if (WD_EN) begin
          wd_cnt_nxt = wd_cnt + 1'b1;
        end
      end
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: only control state is reset; all slave strobes decode from it, so they clear with rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      sel_idx <= '0;
      wd_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      sel_idx <= sel_idx_nxt;
      wd_cnt  <= wd_cnt_nxt;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SLAVES; i++) begin
      bus.wbs_adr_o[i*ADDR_WIDTH +: ADDR_WIDTH]     = bus.wbm_adr_i;
      bus.wbs_dat_o[i*DATA_WIDTH +: DATA_WIDTH]     = bus.wbm_dat_i;
      bus.wbs_sel_o[i*SELECT_WIDTH +: SELECT_WIDTH] = bus.wbm_sel_i;
    end
  end

  // Only the locked slave sees the master's control lines, and only while ACTIVE.
  always_comb begin
    bus.wbs_cyc_o = '0;
    bus.wbs_stb_o = '0;
    bus.wbs_we_o  = '0;
    bus.wbm_dat_o = '0;
    bus.wbm_ack_o = 1'b0;
    bus.wbm_err_o = 1'b0;
    bus.wbm_rty_o = 1'b0;
    case (state)
      ST_ACTIVE: begin
        bus.wbs_cyc_o[sel_idx] = bus.wbm_cyc_i;
        bus.wbs_stb_o[sel_idx] = bus.wbm_stb_i;
        bus.wbs_we_o[sel_idx]  = bus.wbm_we_i;
        bus.wbm_dat_o          = sel_dat;
        bus.wbm_err_o          = sel_err;
        bus.wbm_rty_o          = sel_rty & ~sel_err;
        bus.wbm_ack_o          = sel_ack & ~sel_err & ~sel_rty;
      end
      ST_ERR:  bus.wbm_err_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_mux_n.sv
// Randomized bench for wb_mux_n: a transaction-level model predicts, per cycle, which slave
// is strobed and what the master sees, from the address map and the slave's response timing.
module tb_wb_mux_n;
  localparam int NS  = 4;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;

  logic [AW-1:0] map_a [NS];
  logic [AW-1:0] map_m [NS];

  wb_mux_n_if #(.NUM_SLAVES(NS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW)) bus ();

  wb_mux_n #(
    .NUM_SLAVES(NS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL sim_timeout: bench did not finish within time limit");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference decode: lowest slave whose masked prefix matches.
  function automatic int decode(input logic [AW-1:0] a);
    for (int i = 0; i < NS; i++)
      if (((a ^ map_a[i]) & map_m[i]) == '0) return i;
    return -1;
  endfunction

  function automatic logic [2:0] kind_bits(input int kind);  // {err, rty, ack}
    case (kind)
      0:       return 3'b001;
      1:       return 3'b010;
      2:       return 3'b100;
      3:       return 3'b111;
      default: return 3'b011;
    endcase
  endfunction

  task automatic clear_resp();
    bus.wbs_ack_i = '0;
    bus.wbs_err_i = '0;
    bus.wbs_rty_i = '0;
  endtask

  task automatic master_off();
    bus.wbm_cyc_i = 1'b0;
    bus.wbm_stb_i = 1'b0;
    bus.wbm_we_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      master_off();
      clear_resp();
      @(negedge clk);
      check("idle_stb", bus.wbs_stb_o, 0);
      check("idle_resp", {bus.wbm_err_o, bus.wbm_rty_o, bus.wbm_ack_o}, 0);
      check("idle_dat", bus.wbm_dat_o, 0);
    end
  endtask

  // One master transaction. The selected slave answers `delay` cycles after its strobe
  // rises; delay >= TMO means it never answers and the watchdog must fire.
  task automatic run_xfer(input logic [AW-1:0] adr, input bit we, input int delay,
                          input int kind, input bit spur, input logic [DW-1:0] rdat);
    int            idx, last, spi;
    bit            tmo;
    logic [2:0]    rb, fwd, e_resp;
    logic [DW-1:0] sdat [NS];
    logic [DW-1:0] wdat, e_dat;
    logic [SW-1:0] sel;
    logic [NS-1:0] oh, e_stb, e_we;

    idx  = decode(adr);
    tmo  = (idx >= 0) && (delay >= TMO);
    last = (idx < 0) ? 1 : (tmo ? TMO + 1 : 1 + delay);
    wdat = $urandom;
    sel  = SW'($urandom);
    for (int i = 0; i < NS; i++) sdat[i] = $urandom;
    if (idx >= 0) sdat[idx] = rdat;
    rb   = kind_bits(kind);
    fwd  = rb[2] ? 3'b100 : (rb[1] ? 3'b010 : 3'b001);
    oh   = (idx >= 0) ? NS'(1) << idx : '0;
    spi  = (idx >= 0) ? (idx + 1) % NS : 0;

    for (int c = 0; c <= last; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        bus.wbm_adr_i = adr;
        bus.wbm_dat_i = wdat;
        bus.wbm_sel_i = sel;
        bus.wbm_we_i  = we;
        bus.wbm_cyc_i = 1'b1;
        bus.wbm_stb_i = 1'b1;
        for (int i = 0; i < NS; i++) bus.wbs_dat_i[i*DW +: DW] = sdat[i];
      end
      clear_resp();
      if (idx >= 0 && !tmo && c == last) begin
        bus.wbs_err_i[idx] = rb[2];
        bus.wbs_rty_i[idx] = rb[1];
        bus.wbs_ack_i[idx] = rb[0];
      end
      if (spur && idx >= 0 && c >= 1) begin
        bus.wbs_ack_i[spi] = 1'b1;
        bus.wbs_err_i[spi] = 1'b1;
      end
      @(negedge clk);

      e_stb = '0; e_we = '0; e_resp = '0; e_dat = '0;
      if (idx < 0) begin
        if (c == 1) e_resp = 3'b100;
      end else if (c >= 1 && !(tmo && c == TMO + 1)) begin
        e_stb = oh;
        e_we  = we ? oh : '0;
        e_dat = sdat[idx];
        if (!tmo && c == last) e_resp = fwd;
      end else if (tmo && c == TMO + 1) begin
        e_resp = 3'b100;
      end

      check("stb", bus.wbs_stb_o, e_stb);
      check("cyc", bus.wbs_cyc_o, e_stb);
      check("we", bus.wbs_we_o, e_we);
      check("resp", {bus.wbm_err_o, bus.wbm_rty_o, bus.wbm_ack_o}, e_resp);
      check("rdat", bus.wbm_dat_o, e_dat);
      if (c == 0) begin
        for (int i = 0; i < NS; i++) begin
          check("bc_adr", bus.wbs_adr_o[i*AW +: AW], adr);
          check("bc_dat", bus.wbs_dat_o[i*DW +: DW], wdat);
          check("bc_sel", bus.wbs_sel_o[i*SW +: SW], sel);
        end
      end
    end
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [3:0]    nib;

    map_a[0] = 32'h1000_0000; map_m[0] = 32'hF000_0000;
    map_a[1] = 32'h2000_0000; map_m[1] = 32'hF000_0000;
    map_a[2] = 32'h1000_0000; map_m[2] = 32'hF000_0000;
    map_a[3] = 32'h3000_0000; map_m[3] = 32'hFFFF_0000;
    for (int i = 0; i < NS; i++) begin
      bus.wbs_addr[i*AW +: AW]     = map_a[i];
      bus.wbs_addr_msk[i*AW +: AW] = map_m[i];
    end
    bus.wbm_adr_i = '0;
    bus.wbm_dat_i = '0;
    bus.wbm_sel_i = '0;
    bus.wbs_dat_i = '0;
    master_off();
    clear_resp();

    rst = 1'b1;
    @(negedge clk);
    check("rst_cyc", bus.wbs_cyc_o, 0);
    check("rst_stb", bus.wbs_stb_o, 0);
    check("rst_we", bus.wbs_we_o, 0);
    check("rst_resp", {bus.wbm_err_o, bus.wbm_rty_o, bus.wbm_ack_o}, 0);
    check("rst_dat", bus.wbm_dat_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    run_xfer(32'h2000_0004, 1'b0, 2, 0, 1'b0, 32'hDEAD_BEEF);  // s1 read
    idle(1);
    run_xfer(32'h1000_0010, 1'b1, 1, 0, 1'b0, 32'h0);          // overlap: s0 wins
    idle(1);
    run_xfer(32'h5000_0000, 1'b0, 0, 0, 1'b0, 32'h0);          // unmapped
    idle(1);
    run_xfer(32'h2000_0000, 1'b0, TMO, 0, 1'b0, 32'h0);        // watchdog
    run_xfer(32'h1000_0000, 1'b0, 0, 0, 1'b0, 32'h1234_5678);  // recovery, back-to-back
    run_xfer(32'h2000_0100, 1'b0, TMO - 1, 0, 1'b0, 32'hA5A5_0001);  // response at limit wins
    idle(1);
    run_xfer(32'h2000_0008, 1'b0, 3, 0, 1'b1, 32'h0BAD_F00D);  // spurious s2 ack/err
    for (int k = 0; k < 5; k++) run_xfer(32'h3000_0040, 1'b1, 1, k, 1'b0, 32'h0);  // priority

    // Master abort while s0 pending, then a late s0 ack.
    @(posedge clk); #1;
    bus.wbm_adr_i = 32'h1000_0020;
    bus.wbm_cyc_i = 1'b1;
    bus.wbm_stb_i = 1'b1;
    bus.wbm_we_i  = 1'b0;
    clear_resp();
    @(posedge clk); #1;
    check("abort_pre_stb", bus.wbs_stb_o, 4'b0001);
    @(posedge clk); #1;
    master_off();
    #1;
    check("abort_cyc_same", bus.wbs_cyc_o, 0);
    @(posedge clk); #1;
    bus.wbs_ack_i[0] = 1'b1;
    #1;
    check("late_ack", bus.wbm_ack_o, 0);
    check("late_cyc", bus.wbs_cyc_o, 0);
    idle(1);

    // Reset asserted mid-ACTIVE.
    @(posedge clk); #1;
    bus.wbm_adr_i = 32'h2000_0000;
    bus.wbm_cyc_i = 1'b1;
    bus.wbm_stb_i = 1'b1;
    clear_resp();
    @(posedge clk); #1;
    check("rst_pre_stb", bus.wbs_stb_o, 4'b0010);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_cyc", bus.wbs_cyc_o, 0);
    check("rst_async_stb", bus.wbs_stb_o, 0);
    master_off();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_post_cyc", bus.wbs_cyc_o, 0);
    run_xfer(32'h2000_0010, 1'b0, 0, 0, 1'b0, 32'hCAFE_0002);

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 4))
        0:       nib = 4'h1;
        1:       nib = 4'h2;
        2, 3:    nib = 4'h3;
        default: nib = 4'h5;
      endcase
      a = {nib, 28'($urandom)};
      if (nib == 4'h3 && $urandom_range(0, 1) == 1) a[27:16] = '0;
      run_xfer(a, 1'($urandom_range(0, 1)), $urandom_range(0, 9), $urandom_range(0, 4),
               1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
